// File: rtl/sat_pkg.sv
// sat_pkg: shared encodings for clause evaluation.
//   pol_t   - slot polarity (00 absent, 01 negative, 10 positive, 11 reserved/absent)
//   val_t   - variable value (00 free, 01 false, 10 true, 11 conflict)
//   truth_t - per-literal truth code produced by lit_eval
//   state_t - clause_cell scan FSM state
package sat_pkg;
    typedef enum logic [1:0] {
        POL_ABSENT = 2'b00,
        POL_NEG    = 2'b01,
        POL_POS    = 2'b10,
        POL_RSVD   = 2'b11
    } pol_t;
    typedef enum logic [1:0] {
        VAL_FREE  = 2'b00,
        VAL_FALSE = 2'b01,
        VAL_TRUE  = 2'b10,
        VAL_CONF  = 2'b11
    } val_t;
    typedef enum logic [2:0] {
        LT_ABSENT = 3'd0,
        LT_FALSE  = 3'd1,
        LT_TRUE   = 3'd2,
        LT_FREE   = 3'd3,
        LT_CONF   = 3'd4
    } truth_t;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/lit_eval.sv
// lit_eval: combinational truth of one literal slot.
//   pol   - slot polarity (pol_t encoding)
//   val   - variable value (val_t encoding)
//   truth - LT_ABSENT / LT_FALSE / LT_TRUE / LT_FREE / LT_CONF
module lit_eval
    import sat_pkg::*;
(
    input  logic [1:0] pol,
    input  logic [1:0] val,
    output truth_t     truth
);
    logic present;
    assign present = (pol == POL_POS) || (pol == POL_NEG);
    // A bound literal is true exactly when the value agrees with the polarity.
    always_comb begin
        truth = !present         ? LT_ABSENT :
                val == VAL_FREE  ? LT_FREE   :
                val == VAL_CONF  ? LT_CONF   :
                ((val == VAL_TRUE) == (pol == POL_POS)) ? LT_TRUE : LT_FALSE;
    end
endmodule

// File: rtl/clause_cell.sv
// clause_cell: stores one clause's literal slots and evaluates it serially.
//   clk, rst (async, active-low)   - clock and reset
//   clear_i                        - sync clear of slots, results and FSM
//   wr_i, wr_idx_i, wr_pol_i       - slot polarity write (IDLE only)
//   var_value_i                    - per-slot variable values, snapshotted on eval
//   eval_i                         - evaluation request (ignored while busy)
//   busy_o, done_o                 - SCAN/DONE indication, one-cycle result strobe
//   clausesat_o, unit_o, conflict_o, imp_value_o, unit_idx_o, freelitcnt_o - results
module clause_cell
    import sat_pkg::*;
#(
    parameter int NUM_LITS = 4,
    parameter int IDX_W    = $clog2(NUM_LITS),
    parameter int CNT_W    = $clog2(NUM_LITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  wr_i,
    input  logic [IDX_W-1:0]      wr_idx_i,
    input  logic [1:0]            wr_pol_i,
    input  logic [2*NUM_LITS-1:0] var_value_i,
    input  logic                  eval_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  clausesat_o,
    output logic                  unit_o,
    output logic                  conflict_o,
    output logic                  imp_value_o,
    output logic [IDX_W-1:0]      unit_idx_o,
    output logic [CNT_W-1:0]      freelitcnt_o
);
    logic [1:0]            pol_q [NUM_LITS];
    logic [2*NUM_LITS-1:0] snap_q;
    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic                  fin;
    logic                  sat_a, conf_a, pres_a, upol_a;
    logic [CNT_W-1:0]      free_a;
    logic [IDX_W-1:0]      uidx_a;
    logic                  unit_n, conf_n, last;
    truth_t                t;

    lit_eval u_lit (
        .pol   (pol_q[idx]),
        .val   (snap_q[{idx, 1'b0} +: 2]),
        .truth (t)
    );

    assign last   = idx == IDX_W'(NUM_LITS - 1);
    assign unit_n = !sat_a && free_a == CNT_W'(1) && !conf_a;
    assign conf_n = !sat_a && (conf_a || (free_a == '0 && pres_a));
    assign busy_o = state != IDLE;
    assign done_o = state == DONE;

    // SCAN folds one slot per cycle into the accumulators; the extra
    // cycle flagged by fin turns the completed accumulators into results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pol_q        <= '{default: 2'b00};
            snap_q       <= '0;
            state        <= IDLE;
            idx          <= '0;
            fin          <= 1'b0;
            {sat_a, conf_a, pres_a, upol_a, free_a, uidx_a} <= '0;
            {clausesat_o, unit_o, conflict_o, imp_value_o, unit_idx_o, freelitcnt_o} <= '0;
        end else if (clear_i) begin
            pol_q        <= '{default: 2'b00};
            state        <= IDLE;
            idx          <= '0;
            fin          <= 1'b0;
            {sat_a, conf_a, pres_a, upol_a, free_a, uidx_a} <= '0;
            {clausesat_o, unit_o, conflict_o, imp_value_o, unit_idx_o, freelitcnt_o} <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_i) pol_q[wr_idx_i] <= wr_pol_i;
                    if (eval_i) begin
                        state  <= SCAN;
                        snap_q <= var_value_i;
                        idx    <= '0;
                        fin    <= 1'b0;
                        {sat_a, conf_a, pres_a, upol_a, free_a, uidx_a} <= '0;
                    end
                end
                SCAN: begin
                    if (fin) begin
                        state        <= DONE;
                        fin          <= 1'b0;
                        clausesat_o  <= sat_a;
                        freelitcnt_o <= free_a;
                        unit_o       <= unit_n;
                        conflict_o   <= conf_n;
                        unit_idx_o   <= unit_n ? uidx_a : '0;
                        imp_value_o  <= unit_n && upol_a;
                    end else begin
                        sat_a  <= sat_a || t == LT_TRUE;
                        conf_a <= conf_a || t == LT_CONF;
                        pres_a <= pres_a || t != LT_ABSENT;
                        free_a <= free_a + CNT_W'(t == LT_FREE);
                        if (t == LT_FREE) begin
                            uidx_a <= idx;
                            upol_a <= pol_q[idx] == POL_POS;
                        end
                        idx <= last ? '0 : idx + 1'b1;
                        fin <= last;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_clause_cell.sv
// tb_clause_cell: directed self-checking bench for clause_cell (NUM_LITS=4).
module tb_clause_cell;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear_i = 1'b0;
    logic       wr_i = 1'b0;
    logic [1:0] wr_idx_i = '0;
    logic [1:0] wr_pol_i = '0;
    logic [7:0] var_value_i = '0;
    logic       eval_i = 1'b0;
    logic       busy_o, done_o, clausesat_o, unit_o, conflict_o, imp_value_o;
    logic [1:0] unit_idx_o;
    logic [2:0] freelitcnt_o;
    logic [8:0] res;
    int total = 0;
    int bad = 0;

    // {sat, unit, conflict, imp, unit_idx[1:0], free[2:0]}
    localparam logic [8:0] R_UNIT = 9'b0101_10_001;
    localparam logic [8:0] R_SAT  = 9'b1000_00_000;
    localparam logic [8:0] R_CONF = 9'b0010_00_000;
    localparam logic [8:0] R_FC   = 9'b0010_00_001;

    assign res = {clausesat_o, unit_o, conflict_o, imp_value_o, unit_idx_o, freelitcnt_o};

    clause_cell #(.NUM_LITS(4)) dut (
        .clk(clk), .rst(rst), .clear_i(clear_i), .wr_i(wr_i), .wr_idx_i(wr_idx_i),
        .wr_pol_i(wr_pol_i), .var_value_i(var_value_i), .eval_i(eval_i),
        .busy_o(busy_o), .done_o(done_o), .clausesat_o(clausesat_o), .unit_o(unit_o),
        .conflict_o(conflict_o), .imp_value_o(imp_value_o), .unit_idx_o(unit_idx_o),
        .freelitcnt_o(freelitcnt_o)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [1:0] i, input logic [1:0] p);
        @(negedge clk); wr_i = 1'b1; wr_idx_i = i; wr_pol_i = p;
        @(negedge clk); wr_i = 1'b0;
    endtask

    task automatic run_eval(input logic [7:0] v, output int lat);
        @(negedge clk); var_value_i = v; eval_i = 1'b1;
        @(negedge clk); eval_i = 1'b0; lat = 0;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            @(negedge clk);
            if (done_o) lat = n;
        end
    endtask

    task automatic test_reset;
        #3 rst = 1'b0;
        #1 total++;
        if ({busy_o, done_o, res} !== 11'd0) begin
            bad++; $display("FAIL reset_state got=%b want=0", {busy_o, done_o, res});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_unit;
        int lat;
        wr(2'd0, 2'b10); wr(2'd1, 2'b01); wr(2'd2, 2'b10);
        run_eval(8'h09, lat);
        total++;
        if (lat !== 5) begin bad++; $display("FAIL unit_latency got=%0d want=5", lat); end
        total++;
        if (res !== R_UNIT) begin bad++; $display("FAIL unit_result got=%b want=%b", res, R_UNIT); end
        total++;
        if (busy_o !== 1'b1) begin bad++; $display("FAIL busy_in_done got=%b want=1", busy_o); end
        @(negedge clk); total++;
        if ({done_o, busy_o, res} !== {2'b00, R_UNIT}) begin
            bad++; $display("FAIL hold_after_done got=%b want=%b", {done_o, busy_o, res}, {2'b00, R_UNIT});
        end
    endtask

    task automatic test_sat;
        int lat;
        run_eval(8'h29, lat);
        total++;
        if (res !== R_SAT || lat !== 5) begin
            bad++; $display("FAIL sat_result got=%b lat=%0d want=%b lat=5", res, lat, R_SAT);
        end
    endtask

    task automatic test_conflict;
        int lat;
        run_eval(8'hD9, lat);
        total++;
        if (res !== R_CONF) begin bad++; $display("FAIL conflict_all_false got=%b want=%b", res, R_CONF); end
        wr(2'd3, 2'b01);
        run_eval(8'hC9, lat);
        total++;
        if (res !== R_FC) begin bad++; $display("FAIL conflict_with_free got=%b want=%b", res, R_FC); end
        wr(2'd3, 2'b11);
        run_eval(8'hC9, lat);
        total++;
        if (res !== R_UNIT) begin bad++; $display("FAIL pol11_absent got=%b want=%b", res, R_UNIT); end
    endtask

    task automatic test_scan_isolation;
        int lat = 0;
        int dones = 0;
        logic [8:0] r = '0;
        @(negedge clk); var_value_i = 8'h09; eval_i = 1'b1;
        @(negedge clk); eval_i = 1'b0;
        @(negedge clk);
        total++;
        if (busy_o !== 1'b1) begin bad++; $display("FAIL busy_in_scan got=%b want=1", busy_o); end
        var_value_i = 8'h29; wr_i = 1'b1; wr_idx_i = 2'd2; wr_pol_i = 2'b00; eval_i = 1'b1;
        @(negedge clk); wr_i = 1'b0; eval_i = 1'b0;
        for (int n = 3; n <= 16; n++) begin
            @(negedge clk);
            if (done_o) begin
                dones++;
                if (lat == 0) begin lat = n; r = res; end
            end
        end
        total++;
        if (dones !== 1 || lat !== 5) begin
            bad++; $display("FAIL scan_done_count got=%0d lat=%0d want=1 lat=5", dones, lat);
        end
        total++;
        if (r !== R_UNIT) begin bad++; $display("FAIL scan_snapshot got=%b want=%b", r, R_UNIT); end
        run_eval(8'h09, lat);
        total++;
        if (res !== R_UNIT) begin bad++; $display("FAIL write_dropped got=%b want=%b", res, R_UNIT); end
    endtask

    task automatic test_reset_mid;
        int lat;
        int dones = 0;
        @(negedge clk); var_value_i = 8'h29; eval_i = 1'b1;
        @(negedge clk); eval_i = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1 total++;
        if ({busy_o, done_o, res} !== 11'd0) begin
            bad++; $display("FAIL reset_mid got=%b want=0", {busy_o, done_o, res});
        end
        @(negedge clk); rst = 1'b1;
        repeat (8) begin @(negedge clk); if (done_o) dones++; end
        total++;
        if (dones !== 0) begin bad++; $display("FAIL reset_no_done got=%0d want=0", dones); end
        run_eval(8'h09, lat);
        total++;
        if (res !== 9'd0 || lat !== 5) begin
            bad++; $display("FAIL reset_slots_absent got=%b lat=%0d want=0 lat=5", res, lat);
        end
    endtask

    task automatic test_wr_eval_same;
        int lat;
        @(negedge clk); wr_i = 1'b1; wr_idx_i = 2'd0; wr_pol_i = 2'b10; eval_i = 1'b1; var_value_i = 8'h02;
        @(negedge clk); wr_i = 1'b0; eval_i = 1'b0; lat = 0;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            @(negedge clk);
            if (done_o) lat = n;
        end
        total++;
        if (res !== R_SAT || lat !== 5) begin
            bad++; $display("FAIL wr_with_eval got=%b lat=%0d want=%b lat=5", res, lat, R_SAT);
        end
    endtask

    task automatic test_clear;
        int lat;
        int dones = 0;
        wr(2'd0, 2'b10); wr(2'd1, 2'b01); wr(2'd2, 2'b10);
        run_eval(8'h09, lat);
        total++;
        if (res !== R_UNIT) begin bad++; $display("FAIL clear_setup got=%b want=%b", res, R_UNIT); end
        @(negedge clk); eval_i = 1'b1;
        @(negedge clk); eval_i = 1'b0;
        @(negedge clk); clear_i = 1'b1; eval_i = 1'b1; wr_i = 1'b1; wr_idx_i = 2'd3; wr_pol_i = 2'b10;
        @(negedge clk); clear_i = 1'b0; eval_i = 1'b0; wr_i = 1'b0;
        total++;
        if ({busy_o, done_o, res} !== 11'd0) begin
            bad++; $display("FAIL clear_state got=%b want=0", {busy_o, done_o, res});
        end
        repeat (8) begin @(negedge clk); if (done_o) dones++; end
        total++;
        if (dones !== 0) begin bad++; $display("FAIL clear_no_done got=%0d want=0", dones); end
        run_eval(8'h09, lat);
        total++;
        if (res !== 9'd0 || lat !== 5) begin
            bad++; $display("FAIL clear_empty_eval got=%b lat=%0d want=0 lat=5", res, lat);
        end
    endtask

    initial begin
        test_reset;
        test_unit;
        test_sat;
        test_conflict;
        test_scan_isolation;
        test_reset_mid;
        test_wr_eval_same;
        test_clear;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
